mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle core's shared instruction/data memory port.
- Replaces the zero-latency combinational memory with a word-organised RAM behind a req/ready handshake, with programmable wait states.
- Datapath or controller issues one request and holds it until memReady.
- Supports byte-lane writes and reads.

Parameters:
- DEPTH_WORDS, 16384: number of 32-bit words. Must be a power of two.
- WAIT_CYCLES, 2: extra wait states per access. Legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- memReq  input  1  request strobe; sampled only in IDLE.
- memWrite  input  1  1 = write, 0 = read; captured with memReq.
- memAdr  input  32  byte address; captured with memReq.
- writeData  input  32  write word; captured with memReq.
- byteEn  input  4  write lane enables; bit i covers writeData[8i+7:8i]; captured with memReq.
- readData  output  32  read word; valid while memReady=1, held afterwards.
- memReady  output  1  one-cycle response pulse.
- memErr  output  1  address error flag; qualified by memReady.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, memReady=0, memErr=0, readData=0.
  - Captured request registers cleared.
  - RAM contents are not reset.
  - Reset mid-access aborts it: a pending write is not committed and no memReady is issued.
- Word index = memAdr[2 +: log2(DEPTH_WORDS)]. Bits [1:0] and the upper bits are ignored unless ADDR_CHECK_EN is defined.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if memReq=1, capture memWrite/memAdr/writeData/byteEn and load counter=WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, else RESP. If memReq=0, stay in IDLE.
  - WAIT: decrement counter each cycle. When counter==1, next state is RESP.
  - RESP: memReady=1 for exactly this cycle. Next state is IDLE unconditionally.
- memReq is ignored in WAIT and RESP. Requester keeps inputs stable but the block does not rely on it, because inputs are captured.
- Latency: sample edge at cycle N -> memReady=1 in cycle N+WAIT_CYCLES+1.
- Throughput: next request accepted in the IDLE cycle after RESP, giving at most one access per WAIT_CYCLES+2 cycles.
- Write commit:
  - Enabled lanes are written on the edge entering RESP.
  - Disabled lanes are unchanged.
  - byteEn=0000 is a no-op write that still responds.
  - A read issued in the following transaction sees the new data.
- Read: readData is loaded on the edge entering RESP with the full addressed word and held until the next read response.
- Write response: readData is held at its previous value.
- memErr is 0 whenever memReady=0.

Optional Feature:
- Macro: ADDR_CHECK_EN.
- Defined:
  - Error condition: memAdr[1:0]!=2'b00 (misaligned), or memAdr >= DEPTH_WORDS*4 (out of range).
  - On error, the response keeps normal latency, memErr=1 together with memReady, the write is suppressed, and readData is loaded with 0.
- Undefined:
  - memErr is tied to 0, low address bits are ignored, and the address wraps modulo DEPTH_WORDS*4.

Test Plan:
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 with byteEn=1111, then read 0x10 -> memReady exactly 3 cycles after each sample edge; read returns 0xDEADBEEF; memErr=0.
- Byte lanes: word 0x20 = 0x11223344, write 0xAABBCCDD with byteEn=0101 -> read returns 0x11BB33DD. A byteEn=0000 write leaves the word unchanged and still pulses memReady.
- WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4 with memReq held high -> memReady in cycles N+1 and N+3. memReq in the RESP cycle is not accepted. Exactly one pulse per access.
- Reset during WAIT of a write to 0x30 (old value 0x5) -> memReady never asserts, outputs return to 0 immediately (asynchronously), and a read of 0x30 after reset returns 0x5.
- ADDR_CHECK_EN with DEPTH_WORDS=16: read 0x42 and write 0x40 -> memReady with memErr=1, readData=0, RAM unchanged. Without the macro, the write to 0x40 lands at word 0 and memErr=0.

Source files
------------

// File: rtl/mem_responder.sv
// Word-organised RAM responder behind a req/ready handshake with WAIT_CYCLES wait states.
// Optional ADDR_CHECK_EN macro flags misaligned/out-of-range accesses via memErr.
module mem_responder #(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReq,
  input  logic        memWrite,
  input  logic [31:0] memAdr,
  input  logic [31:0] writeData,
  input  logic [3:0]  byteEn,
  output logic [31:0] readData,
  output logic        memReady,
  output logic        memErr,
  output logic [1:0]  o_dbg_state
);

  // Handshake: memReq is sampled only in IDLE and all request fields are captured on
  // that edge; memReady pulses for exactly one cycle, with memErr/readData valid with it.
  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_wr;
  logic [31:0] r_adr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_take;
  logic             w_wr;
  logic [31:0]      w_adr;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_enter_resp;
  logic             w_commit;

  assign w_take = (r_state == S_IDLE) && memReq;

  // With zero wait states the commit edge is the capture edge, so use live inputs then.
  assign w_wr    = (r_state == S_IDLE) ? memWrite  : r_wr;
  assign w_adr   = (r_state == S_IDLE) ? memAdr    : r_adr;
  assign w_wdata = (r_state == S_IDLE) ? writeData : r_wdata;
  assign w_be    = (r_state == S_IDLE) ? byteEn    : r_be;
  assign w_idx   = w_adr[2 +: IDX_W];

`ifdef ADDR_CHECK_EN
  assign w_err = (w_adr[1:0] != 2'b00) || ((w_adr >> (IDX_W + 2)) != 32'd0);
`else
  logic w_unused_bits;
  assign w_err         = 1'b0;
  assign w_unused_bits = ^{w_adr[31:IDX_W+2], w_adr[1:0]};
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (memReq) begin
          w_cnt_next = WAIT_LD;
          w_next     = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
  // rst gate keeps a same-edge commit from landing while reset is held.
  assign w_commit     = w_enter_resp && w_wr && !w_err && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_adr   <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_take) begin
        r_wr    <= memWrite;
        r_adr   <= memAdr;
        r_wdata <= writeData;
        r_be    <= byteEn;
      end
      if (w_enter_resp) begin
        r_err <= w_err;
        if (w_err)      r_rdata <= 32'd0;
        else if (!w_wr) r_rdata <= r_mem[w_idx];
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign memReady    = (r_state == S_RESP);
  assign memErr      = memReady & r_err;
  assign readData    = r_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder: two instances (2 and 0 wait states, 16 words)
// checked against a word-array reference model.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic        wr    [2];
  logic [31:0] adr   [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];
  logic [1:0]  dbg   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS(16),
      .WAIT_CYCLES((g == 0) ? 2 : 0)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .memReq     (req[g]),
      .memWrite   (wr[g]),
      .memAdr     (adr[g]),
      .writeData  (wdata[g]),
      .byteEn     (be[g]),
      .readData   (rdata[g]),
      .memReady   (rdy[g]),
      .memErr     (err[g]),
      .o_dbg_state(dbg[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // reference model
  logic [31:0] m_mem [2][16];
  logic [31:0] m_rd  [2];
  int          wc    [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
`ifdef ADDR_CHECK_EN
    return (a % 4 != 0) || (a >= 32'd64);
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // driver: one full transaction, DUT d must be idle on entry
  task automatic access(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] dt, input logic [3:0] b, input bit hold);
    int k;
    int idx;
    bit e;
    req[d] = 1'b1; wr[d] = w; adr[d] = a; wdata[d] = dt; be[d] = b;
    @(posedge clk); #1;
    // scramble inputs after capture: DUT must not depend on them
    req[d]   = hold ? 1'b1 : 1'($urandom_range(0, 1));
    wr[d]    = 1'($urandom_range(0, 1));
    adr[d]   = $urandom;
    wdata[d] = $urandom;
    be[d]    = 4'($urandom_range(0, 15));
    k = 1;
    while (!rdy[d] && k <= 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(wc[d] + 1));
    e   = addr_err(a);
    idx = int'((a / 4) % 16);
    if (e) m_rd[d] = 32'd0;
    else if (!w) m_rd[d] = m_mem[d][idx];
    else m_mem[d][idx] = merge(m_mem[d][idx], dt, b);
    chk("ready", 32'(rdy[d]), 32'd1);
    chk("rdata", rdata[d], m_rd[d]);
    chk("err", 32'(err[d]), 32'(e));
    @(posedge clk); #1;
    chk("pulse", 32'(rdy[d]), 32'd0);
    chk("err_idle", 32'(err[d]), 32'd0);
    req[d] = hold;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    wc[0] = 2;
    wc[1] = 0;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; adr[d] = 32'd0; wdata[d] = 32'd0; be[d] = 4'd0;
      m_rd[d] = 32'd0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(rdy[d]), 32'd0);
      chk("rst_err", 32'(err[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // known contents everywhere
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) access(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);

    // full-word write then read, two wait states
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    chk("deadbeef", rdata[0], 32'hDEADBEEF);

    // byte lanes and empty write
    access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    chk("lanes", rdata[0], 32'h11BB33DD);
    access(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    chk("be_zero", rdata[0], 32'h11BB33DD);

    // zero wait states, memReq held across the response
    access(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    access(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);

    // reset in the middle of a write
    access(0, 1'b1, 32'h30, 32'h5, 4'hF, 1'b0);
    req[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h30; wdata[0] = 32'h99999999; be[0] = 4'hF;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_ready", 32'(rdy[0]), 32'd0);
    chk("arst_rdata", rdata[0], 32'd0);
    chk("arst_err", 32'(err[0]), 32'd0);
    m_rd[0] = 32'd0;
    m_rd[1] = 32'd0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("arst_noresp", 32'(rdy[0]), 32'd0);
    end
    access(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
    chk("arst_keep", rdata[0], 32'h5);

    // address handling at the top of a 16-word RAM
`ifdef ADDR_CHECK_EN
    access(0, 1'b0, 32'h42, 32'h0, 4'h0, 1'b0);
    chk("misalign_rd", rdata[0], 32'h0);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    a = rdata[0];
    access(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    chk("oor_nowrite", rdata[0], a);
`else
    access(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    chk("wrap", rdata[0], 32'hCAFEF00D);
`endif

    // random traffic
    repeat (80) begin
      int d;
      d = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      access(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
